// File: rtl/pe_result_drain.sv
// pe_result_drain: captures a full PE-array frame into a two-bank
// ping-pong buffer and streams it out one word per cycle, row-major.
module pe_result_drain #(
    parameter  int col            = 16,
    parameter  int row            = 2,
    parameter  int para_int_bits  = 7,
    parameter  int para_frac_bits = 9,
    localparam int DW             = para_int_bits + para_frac_bits,
    localparam int NW             = row * col,
    localparam int RW             = (row > 1) ? $clog2(row) : 1,
    localparam int CW             = (col > 1) ? $clog2(col) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cap_valid,
    input  logic [NW*DW-1:0] cap_data,
    output logic             cap_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic [RW-1:0]    out_row,
    output logic [CW-1:0]    out_col,
    output logic             out_last,
    output logic             ovf_err
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [NW*DW-1:0] r_bank [2];
    logic [1:0]       r_full;
    logic [1:0]       w_full_nxt;
    logic             r_wr_sel;
    logic             r_rd_sel;
    logic             w_rd_sel_nxt;
    logic [RW-1:0]    r_row;
    logic [RW-1:0]    w_row_nxt;
    logic [CW-1:0]    r_col;
    logic [CW-1:0]    w_col_nxt;
    logic [DW-1:0]    r_data;
    logic [DW-1:0]    w_rd_word;
    logic             r_ovf;

    logic             w_cap;
    logic             w_drop;
    logic             w_fire;
    logic             w_eof;
    logic             w_load;
    logic             w_col_end;
    logic             w_row_end;
    logic             w_last;

    // Ready looks only at registered flags, never at out_ready.
    assign cap_ready = ~r_full[r_wr_sel];
    assign w_cap     = cap_valid & cap_ready;
    assign w_drop    = cap_valid & ~cap_ready;

    assign w_col_end = (r_col == CW'(col - 1));
    assign w_row_end = (r_row == RW'(row - 1));
    assign w_last    = w_row_end & w_col_end;
    assign w_fire    = out_valid & out_ready;
    assign w_eof     = w_fire & w_last;

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state; back-to-back frames stay in DRAIN without a bubble
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_full[r_rd_sel]) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_eof && !r_full[~r_rd_sel]) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        out_valid = (r_state == S_DRAIN);
        out_last  = (r_state == S_DRAIN) & w_last;
    end

    // Read pointer advance; the word at the next pointer is prefetched
    always_comb begin
        w_load       = 1'b0;
        w_rd_sel_nxt = r_rd_sel;
        w_row_nxt    = r_row;
        w_col_nxt    = r_col;
        if (r_state == S_IDLE) begin
            w_load = r_full[r_rd_sel];
        end else if (w_fire) begin
            w_load = 1'b1;
            if (w_last) begin
                w_rd_sel_nxt = ~r_rd_sel;
                w_row_nxt    = '0;
                w_col_nxt    = '0;
            end else if (w_col_end) begin
                w_row_nxt = r_row + 1'b1;
                w_col_nxt = '0;
            end else begin
                w_col_nxt = r_col + 1'b1;
            end
        end
    end

    always_comb begin
        int w_off;
        w_off     = int'(w_row_nxt) * col + int'(w_col_nxt);
        w_rd_word = r_bank[w_rd_sel_nxt][w_off*DW +: DW];
    end

    always_comb begin
        w_full_nxt = r_full;
        if (w_eof) begin
            w_full_nxt[r_rd_sel] = 1'b0;
        end
        if (w_cap) begin
            w_full_nxt[r_wr_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full   <= 2'b00;
            r_wr_sel <= 1'b0;
            r_rd_sel <= 1'b0;
            r_row    <= '0;
            r_col    <= '0;
            r_data   <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_full   <= w_full_nxt;
            r_rd_sel <= w_rd_sel_nxt;
            r_row    <= w_row_nxt;
            r_col    <= w_col_nxt;
            if (w_cap) begin
                r_wr_sel <= ~r_wr_sel;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
            if (w_load) begin
                r_data <= w_rd_word;
            end
        end
    end

    // Bank storage carries no reset; the full flags qualify it
    always_ff @(posedge clk) begin
        if (w_cap) begin
            r_bank[r_wr_sel] <= cap_data;
        end
    end

    assign out_data = r_data;
    assign out_row  = r_row;
    assign out_col  = r_col;
    assign ovf_err  = r_ovf;

endmodule

// File: tb/tb_pe_result_drain.sv
// tb_pe_result_drain: directed checks of capture, drain order,
// back-to-back frames, overflow, backpressure and reset.
module tb_pe_result_drain;

    logic         clk;
    logic         rst;
    logic         cap_valid;
    logic [511:0] cap_data;
    logic         cap_ready;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  out_data;
    logic [0:0]   out_row;
    logic [3:0]   out_col;
    logic         out_last;
    logic         ovf_err;

    int n_chk;
    int n_pass;

    pe_result_drain dut (
        .clk       (clk),
        .rst       (rst),
        .cap_valid (cap_valid),
        .cap_data  (cap_data),
        .cap_ready (cap_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last),
        .ovf_err   (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] wexp(input int base, input int step,
                                         input int i);
        return 16'(base + i * step);
    endfunction

    function automatic logic [511:0] mkfr(input int base, input int step);
        logic [511:0] f;
        for (int i = 0; i < 32; i++) begin
            f[i*16 +: 16] = wexp(base, step, i);
        end
        return f;
    endfunction

    function automatic logic [15:0] negw(input int i);
        case (i)
            0:       return 16'h8000;
            1:       return 16'hFE00;
            31:      return 16'hFFFF;
            default: return 16'h8000 | 16'(i * 'h123);
        endcase
    endfunction

    function automatic logic [511:0] mkneg();
        logic [511:0] f;
        for (int i = 0; i < 32; i++) begin
            f[i*16 +: 16] = negw(i);
        end
        return f;
    endfunction

    initial begin
        logic [15:0] lfsr;
        logic [21:0] saved;
        logic        stalled;
        int          e;
        int          cyc;
        logic        found;

        n_chk     = 0;
        n_pass    = 0;
        rst       = 1'b1;
        cap_valid = 1'b0;
        cap_data  = '0;
        out_ready = 1'b0;
        tick();
        tick();

        // reset state
        chk("rst_cap_ready", 32'(cap_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_ovf", 32'(ovf_err), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_row_col", 32'({out_row, out_col}), 0);
        rst = 1'b0;
        tick();

        // single frame, ramp 0..31
        out_ready = 1'b1;
        cap_data  = mkfr(0, 1);
        cap_valid = 1'b1;
        tick();
        cap_valid = 1'b0;
        chk("t1_latency", 32'(out_valid), 0);
        tick();
        for (int i = 0; i < 32; i++) begin
            chk("t1_valid", 32'(out_valid), 1);
            chk("t1_data", 32'(out_data), 32'(i));
            chk("t1_row", 32'(out_row), 32'(i / 16));
            chk("t1_col", 32'(out_col), 32'(i % 16));
            chk("t1_last", 32'(out_last), 32'(i == 31));
            tick();
        end
        chk("t1_idle", 32'(out_valid), 0);
        chk("t1_cap_ready", 32'(cap_ready), 1);

        // back-to-back frames A then B, no bubble
        cap_data  = mkfr('h1111, 0);
        cap_valid = 1'b1;
        tick();
        for (int k = 0; k <= 65; k++) begin
            chk("t2_valid", 32'(out_valid), 32'(k >= 1 && k <= 64));
            if (k >= 1 && k <= 64) begin
                chk("t2_data", 32'(out_data),
                    (k <= 32) ? 32'h1111 : 32'h2222);
            end
            chk("t2_cap_ready", 32'(cap_ready), 32'(k < 5 || k >= 33));
            if (k == 4) begin
                cap_valid = 1'b1;
                cap_data  = mkfr('h2222, 0);
            end else begin
                cap_valid = 1'b0;
            end
            tick();
        end

        // overflow with out_ready held low
        out_ready = 1'b0;
        cap_data  = mkfr('h3000, 1);
        cap_valid = 1'b1;
        tick();
        chk("t3_ready_1", 32'(cap_ready), 1);
        cap_data = mkfr('h4000, 1);
        tick();
        chk("t3_ready_0", 32'(cap_ready), 0);
        cap_data = mkfr('h7FFF, 0);
        tick();
        cap_valid = 1'b0;
        chk("t3_ovf", 32'(ovf_err), 1);
        chk("t3_cap_ready", 32'(cap_ready), 0);
        tick();
        chk("t3_stall_valid", 32'(out_valid), 1);
        chk("t3_stall_data", 32'(out_data), 32'h3000);
        out_ready = 1'b1;
        for (int j = 0; j < 64; j++) begin
            chk("t3_valid", 32'(out_valid), 1);
            chk("t3_data", 32'(out_data),
                (j < 32) ? 32'(wexp('h3000, 1, j))
                         : 32'(wexp('h4000, 1, j - 32)));
            tick();
        end
        chk("t3_idle", 32'(out_valid), 0);

        // backpressure on negative values
        lfsr      = 16'hACE1;
        e         = 0;
        cyc       = 0;
        stalled   = 1'b0;
        saved     = '0;
        cap_data  = mkneg();
        cap_valid = 1'b1;
        while (e < 32 && cyc < 400) begin
            lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            out_ready = lfsr[0];
            if (stalled) begin
                chk("t4_hold", 32'({out_data, out_row, out_col, out_last}),
                    32'(saved));
            end
            if (out_valid) begin
                chk("t4_data", 32'(out_data), 32'(negw(e)));
                chk("t4_pos", 32'({out_row, out_col}), 32'(e));
                chk("t4_last", 32'(out_last), 32'(e == 31));
            end
            stalled = out_valid & ~out_ready;
            saved   = {out_data, out_row, out_col, out_last};
            if (out_valid && out_ready) begin
                e++;
            end
            tick();
            cap_valid = 1'b0;
            cyc++;
        end
        chk("t4_count", 32'(e), 32);
        chk("t4_idle", 32'(out_valid), 0);

        // reset mid-drain with both banks full
        out_ready = 1'b1;
        cap_data  = mkfr('h5000, 1);
        cap_valid = 1'b1;
        tick();
        cap_data = mkfr('h5100, 1);
        tick();
        cap_valid = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            chk("t5_data", 32'(out_data), 32'(wexp('h5000, 1, k - 1)));
            tick();
        end
        chk("t5_word11", 32'(out_data), 32'(wexp('h5000, 1, 11)));
        #2;
        rst = 1'b1;
        #1;
        chk("t5_valid", 32'(out_valid), 0);
        chk("t5_last", 32'(out_last), 0);
        chk("t5_data_rst", 32'(out_data), 0);
        chk("t5_row_col", 32'({out_row, out_col}), 0);
        chk("t5_ovf", 32'(ovf_err), 0);
        chk("t5_cap_ready", 32'(cap_ready), 1);
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t5_stay_idle", 32'(out_valid), 0);
        end

        // capture offered on the edge that frees a bank
        out_ready = 1'b0;
        cap_data  = mkfr('h6000, 1);
        cap_valid = 1'b1;
        tick();
        cap_data = mkfr('h6100, 1);
        tick();
        cap_valid = 1'b0;
        out_ready = 1'b1;
        found     = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            if (out_valid && out_last) begin
                found = 1'b1;
            end else begin
                tick();
            end
        end
        chk("t6_found_last", 32'(found), 1);
        chk("t6_last_data", 32'(out_data), 32'(wexp('h6000, 1, 31)));
        chk("t6_cap_ready_0", 32'(cap_ready), 0);
        chk("t6_ovf_before", 32'(ovf_err), 0);
        cap_data  = mkfr('h7FFF, 0);
        cap_valid = 1'b1;
        tick();
        chk("t6_ovf_after", 32'(ovf_err), 1);
        for (int j = 0; j < 64; j++) begin
            if (j == 0) begin
                chk("t6_cap_ready_1", 32'(cap_ready), 1);
                cap_data  = mkfr('h6200, 1);
                cap_valid = 1'b1;
            end else begin
                cap_valid = 1'b0;
            end
            chk("t6_valid", 32'(out_valid), 1);
            chk("t6_data", 32'(out_data),
                (j < 32) ? 32'(wexp('h6100, 1, j))
                         : 32'(wexp('h6200, 1, j - 32)));
            tick();
        end
        chk("t6_idle", 32'(out_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pe_result_drain.md
# pe_result_drain

Read-side companion of the PE array. Captures one complete frame of rounded `data_out` words from all ROW×COL PEs in a single cycle, holds it in a two-bank ping-pong buffer, and streams the words out one per cycle over a valid/ready interface in row-major order. The array can deposit the next frame while the previous one is still draining.

## Interface
Parameters:
- `col`, 16, PE columns in the array
- `row`, 2, PE rows in the array
- `para_int_bits`, 7, integer bits of one PE result word
- `para_frac_bits`, 9, fractional bits of one PE result word; word width DW = int + frac = 16

Ports:
- `clk`  in  1  single clock, all logic on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `cap_valid`  in  1  array presents a complete frame on `cap_data` this cycle
- `cap_data`  in  row*col*DW  flattened frame; PE (r,c) occupies bits [(r*col+c)*DW +: DW]
- `cap_ready`  out  1  at least one bank is empty; capture accepted when `cap_valid & cap_ready`
- `out_valid`  out  1  `out_data` holds a valid word
- `out_ready`  in  1  downstream accepts the word this cycle
- `out_data`  out  DW  result word, two's-complement fixed point, passed through unchanged
- `out_row`  out  clog2(row) (min 1)  row index of the current word
- `out_col`  out  clog2(col)  column index of the current word
- `out_last`  out  1  current word is the final word (row-1, col-1) of its frame
- `ovf_err`  out  1  sticky: a frame was offered while both banks were full

## Operation
- Storage: two banks of row*col DW-bit words, each with a registered `full` flag. `wr_sel` names the next bank to fill and `rd_sel` the bank being drained. Both pointers reset to bank 0.
- `cap_ready` = NOT(full[wr_sel]). It is derived only from registered state, so it never depends on the same-cycle `out_ready`.
- Capture: on `cap_valid & cap_ready`, the whole `cap_data` is written into bank `wr_sel`, full[wr_sel] is set and `wr_sel` toggles.
- Drop: on `cap_valid & !cap_ready`, the frame is discarded, bank contents are unchanged and `ovf_err` sets. `ovf_err` clears only on `rst`.
- Drain FSM:
  - IDLE: `out_valid` = 0. When full[rd_sel] = 1, go to DRAIN with the index counter `idx` = 0.
  - DRAIN: `out_valid` = 1 and `out_data` = bank[rd_sel][idx], with `out_row` = idx / col and `out_col` = idx % col. On `out_valid & out_ready`, `idx` increments.
  - End of frame: on the handshake at idx = row*col-1 (`out_last` = 1), full[rd_sel] clears, `rd_sel` toggles and `idx` wraps to 0.
  - After the last word: if the other bank is already full, stay in DRAIN with no bubble, so word 0 of the next frame is presented the following cycle. Otherwise return to IDLE.
- Word order within a frame: row-major, (0,0), (0,1) … (0,col-1), (1,0) … (row-1,col-1).
- Stall: while `out_valid & !out_ready`, `out_data`, `out_row`, `out_col` and `out_last` hold stable.
- Simultaneous events:
  - A capture into the empty bank during a drain of the other bank is legal and does not disturb the drain.
  - A bank freed by the last-word handshake becomes capturable on the next cycle, not the same cycle.
- Reset mid-operation clears both full flags, both pointers, `idx`, the FSM (to IDLE) and `ovf_err`. Partially drained frames are lost. Bank contents need not be cleared.
- Reset values: `cap_ready` = 1; `out_valid`, `out_last`, `ovf_err`, `out_row`, `out_col` and `out_data` = 0.

## Timing
- Capture to first output:
  - A capture accepted at edge N into an idle drain gives `out_valid` = 1 after edge N+1, with word (0,0).
  - One cycle is spent in the IDLE→DRAIN transition, and `out_data` comes from a registered read.
- Throughput: one word per cycle while `out_ready` = 1. A full frame drains in row*col cycles (32 by default). There are no bubbles between back-to-back frames.
- `cap_ready` deasserts the cycle after the second bank fills. It reasserts the cycle after the final word of the draining frame is accepted.
- The array may capture at most one frame per cycle. A sustained rate of one frame per row*col cycles is lossless.

## Test plan
- Single frame: load PE (r,c) = r*col+c, pulse `cap_valid` once, hold `out_ready` = 1.
  - `out_valid` rises one cycle later.
  - 32 consecutive words 0..31 appear with matching `out_row`/`out_col`.
  - `out_last` is set only on word 31, then `out_valid` = 0 and `cap_ready` = 1.
- Back-to-back: capture frame A (all words 0x1111), then frame B (0x2222) 5 cycles later.
  - The output shows 32×0x1111 immediately followed by 32×0x2222 with no idle cycle.
  - `cap_ready` = 0 from the cycle after B is captured until one cycle after A's last word is accepted.
- Overflow: with `out_ready` = 0, capture 2 frames, then assert `cap_valid` with 0x7FFF data.
  - `cap_ready` = 0 and `ovf_err` = 1.
  - Releasing `out_ready` yields only the first two frames, with no 0x7FFF words.
- Backpressure: toggle `out_ready` pseudo-randomly on a frame of negative values (0x8000, 0xFE00, …).
  - Every word arrives exactly once, in order, bit-exact.
  - Output fields are stable during every stalled cycle.
- Reset mid-drain: assert `rst` after word 10 of a frame, with the other bank also full.
  - All outputs go to their reset values asynchronously and `cap_ready` = 1.
  - After release with no new capture, `out_valid` stays 0.
- Capture on freeing edge: both banks full, and `cap_valid` is asserted in the same cycle as the last-word handshake.
  - That frame is dropped and `ovf_err` sets.
  - A capture on the next cycle is accepted.
